// File: rtl/viterbi_ber_ctrl_if.sv
// rtl/viterbi_ber_ctrl_if.sv - encoder/channel/decoder signal bundle for the BER controller
interface viterbi_ber_ctrl_if;
    logic       encoder_i_o;
    logic       enable_encoder_o;
    logic       enc_valid_i;
    logic [1:0] enc_d_i;
    logic [1:0] chan_o;
    logic       enable_decoder_o;
    logic       dec_d_i;
    logic [1:0] err_inj_o;

    modport master (
        output encoder_i_o, enable_encoder_o, chan_o, enable_decoder_o, err_inj_o,
        input  enc_valid_i, enc_d_i, dec_d_i
    );

    modport slave (
        input  encoder_i_o, enable_encoder_o, chan_o, enable_decoder_o, err_inj_o,
        output enc_valid_i, enc_d_i, dec_d_i
    );
endinterface

// File: rtl/viterbi_ber_ctrl.sv
// rtl/viterbi_ber_ctrl.sv - PRBS source, error-injecting channel and BER counter around a Viterbi codec
module viterbi_ber_ctrl #(
    parameter int          WORDS      = 256,
    parameter int          ERR_PERIOD = 156,
    parameter int          DEC_LAT    = 48,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [1:0]          err_mode_i,
    viterbi_ber_ctrl_if.master  codec,
    output logic                busy_o,
    output logic                done_o,
    output logic [15:0]         chan_err_ct_o,
    output logic [15:0]         bit_err_ct_o
);
    // Reference bits must line up with decoder output: one encoder register,
    // one channel register, then the decoder latency.
    localparam int DL = DEC_LAT + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t       state, state_nx;
    logic [31:0]  cnt;
    logic [15:0]  lfsr;
    logic [1:0]   mode;
    logic [31:0]  phase;
    logic         pend;
    logic [DL-1:0] ref_v, ref_b;

    logic         active;
    logic         launch;
    logic         hit;
    logic [1:0]   mask;
    logic [16:0]  cct_sum;
    logic         lfsr_fb;

    // Next-state decode and status outputs
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_i) state_nx = S_RUN;
            S_RUN:   if (cnt == 32'(WORDS - 1)) state_nx = S_DRAIN;
            S_DRAIN: if (cnt == 32'(DL - 1)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign active                 = (state == S_RUN) || (state == S_DRAIN);
    assign launch                 = (state == S_IDLE) && start_i;
    assign busy_o                 = active;
    assign done_o                 = (state == S_DONE);
    assign codec.enable_encoder_o = (state == S_RUN);
    assign codec.encoder_i_o      = (state == S_RUN) && lfsr[0];
    assign lfsr_fb                = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // Error mask: the periodic word, plus the following valid word in double-burst mode
    always_comb begin
        mask = 2'b00;
        hit  = (phase == 32'(ERR_PERIOD - 1));
        if (active && codec.enc_valid_i && (hit || pend)) begin
            case (mode)
                2'd1:    mask = 2'b01;
                2'd2:    mask = 2'b11;
                2'd3:    mask = 2'b11;
                default: mask = 2'b00;
            endcase
        end
        cct_sum = {1'b0, chan_err_ct_o} + 17'(mask[0]) + 17'(mask[1]);
    end

    // State register and per-phase cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (!active || state_nx != state)
                cnt <= '0;
            else
                cnt <= cnt + 32'd1;
        end
    end

    // PRBS generator and run-mode latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED;
            mode <= 2'd0;
        end else if (launch) begin
            lfsr <= SEED;
            mode <= err_mode_i;
        end else if (state == S_RUN) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end

    // Channel register: corrupted symbol, valid and injected-bit report
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            codec.chan_o           <= 2'b00;
            codec.enable_decoder_o <= 1'b0;
            codec.err_inj_o        <= 2'b00;
        end else begin
            codec.chan_o           <= codec.enc_d_i ^ mask;
            codec.enable_decoder_o <= codec.enc_valid_i;
            codec.err_inj_o        <= mask;
        end
    end

    // Valid channel-word position within the injection period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
            pend  <= 1'b0;
        end else if (launch) begin
            phase <= '0;
            pend  <= 1'b0;
        end else if (active && codec.enc_valid_i) begin
            phase <= hit ? '0 : phase + 32'd1;
            pend  <= (mode == 2'd3) && hit;
        end
    end

    // Reference delay line of transmitted bits with valid tags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_v <= '0;
            ref_b <= '0;
        end else begin
            ref_v <= {ref_v[DL-2:0], (state == S_RUN)};
            ref_b <= {ref_b[DL-2:0], (state == S_RUN) && lfsr[0]};
        end
    end

    // Saturating channel-error and bit-error counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chan_err_ct_o <= '0;
            bit_err_ct_o  <= '0;
        end else if (launch) begin
            chan_err_ct_o <= '0;
            bit_err_ct_o  <= '0;
        end else if (active) begin
            chan_err_ct_o <= cct_sum[16] ? 16'hFFFF : cct_sum[15:0];
            if (ref_v[DL-1] && (codec.dec_d_i != ref_b[DL-1]) && (bit_err_ct_o != 16'hFFFF))
                bit_err_ct_o <= bit_err_ct_o + 16'd1;
        end
    end
endmodule

// File: tb/tb_viterbi_ber_ctrl.sv
// tb/tb_viterbi_ber_ctrl.sv - self-checking bench for viterbi_ber_ctrl
module tb_viterbi_ber_ctrl;
    localparam int          WORDS = 256;
    localparam int          EP    = 156;
    localparam int          DLAT  = 48;
    localparam int          DL    = DLAT + 2;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  err_mode_i = 2'd0;
    logic        busy_o, done_o;
    logic [15:0] chan_err_ct_o, bit_err_ct_o;
    logic        flip_req = 1'b0;

    viterbi_ber_ctrl_if cif();

    viterbi_ber_ctrl #(.WORDS(WORDS), .ERR_PERIOD(EP), .DEC_LAT(DLAT), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .err_mode_i(err_mode_i), .codec(cif),
        .busy_o(busy_o), .done_o(done_o), .chan_err_ct_o(chan_err_ct_o), .bit_err_ct_o(bit_err_ct_o)
    );

    always #5 clk = ~clk;

    // Encoder stub: one-cycle latency, symbol {b, ~b}; true bit carried alongside
    logic tb1, tb2;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cif.enc_valid_i <= 1'b0;
            cif.enc_d_i     <= 2'b00;
            tb1 <= 1'b0;
            tb2 <= 1'b0;
        end else begin
            cif.enc_valid_i <= cif.enable_encoder_o;
            cif.enc_d_i     <= {cif.encoder_i_o, ~cif.encoder_i_o};
            tb1 <= cif.encoder_i_o;
            tb2 <= tb1;
        end
    end

    // Ideal decoder stub: returns the true bit DEC_LAT cycles later, optional forced inversion
    logic [DLAT-1:0] pb;
    always @(posedge clk or negedge rst) begin
        if (!rst) pb <= '0;
        else      pb <= {pb[DLAT-2:0], tb2};
    end
    assign cif.dec_d_i = pb[DLAT-1] ^ flip_req;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: run position, word count and expected registered outputs
    bit          bits [WORDS];
    int          m_k = -1;
    int          m_w = 0;
    int          m_mode = 0;
    int          m_chan = 0, m_endec = 0, m_inj = 0, m_cct = 0, m_bct = 0;

    task automatic cmp_cycle();
        int  x_en, x_bit, x_busy, x_done, mask;
        bit  act, hit;
        cyc++;
        if (!rst) begin
            check("rst_enc_en", cif.enable_encoder_o, 0);
            check("rst_enc_i", cif.encoder_i_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_done", done_o, 0);
            check("rst_chan", cif.chan_o, 0);
            check("rst_endec", cif.enable_decoder_o, 0);
            check("rst_inj", cif.err_inj_o, 0);
            check("rst_cct", chan_err_ct_o, 0);
            check("rst_bct", bit_err_ct_o, 0);
            m_k = -1; m_w = 0; m_chan = 0; m_endec = 0; m_inj = 0; m_cct = 0; m_bct = 0;
            return;
        end
        x_en   = (m_k >= 0 && m_k < WORDS) ? 1 : 0;
        x_bit  = x_en ? int'(bits[m_k]) : 0;
        x_busy = (m_k >= 0 && m_k < WORDS + DL) ? 1 : 0;
        x_done = (m_k == WORDS + DL) ? 1 : 0;
        check("enc_en", cif.enable_encoder_o, x_en);
        check("enc_i", cif.encoder_i_o, x_bit);
        check("busy", busy_o, x_busy);
        check("done", done_o, x_done);
        check("chan", cif.chan_o, m_chan);
        check("endec", cif.enable_decoder_o, m_endec);
        check("inj", cif.err_inj_o, m_inj);
        check("cct", chan_err_ct_o, m_cct);
        check("bct", bit_err_ct_o, m_bct);

        act  = (m_k >= 0 && m_k < WORDS + DL);
        mask = 0;
        if (act && cif.enc_valid_i) begin
            hit = (m_w % EP == EP - 1) || (m_mode == 3 && m_w % EP == 0 && m_w > 0);
            if (hit) mask = (m_mode == 1) ? 1 : (m_mode == 0) ? 0 : 3;
            m_w++;
        end
        m_chan  = int'(cif.enc_d_i) ^ mask;
        m_endec = int'(cif.enc_valid_i);
        m_inj   = mask;
        m_cct   = m_cct + (mask & 1) + (mask >> 1);
        if (m_cct > 65535) m_cct = 65535;
        if (m_k >= DL && m_k < WORDS + DL && cif.dec_d_i != bits[m_k - DL] && m_bct < 65535)
            m_bct++;

        if (m_k < 0) begin
            if (start_i) begin
                m_k = 0; m_w = 0; m_cct = 0; m_bct = 0; m_mode = int'(err_mode_i);
            end
        end else if (m_k == WORDS + DL) begin
            m_k = -1;
        end else begin
            m_k++;
        end
    endtask

    task automatic run_one(input int mode, input bit flip, output int kd,
                           output logic [15:0] cap, output int inj3, output int injnz);
        kd = -1; cap = '0; inj3 = 0; injnz = 0;
        start_i = 1'b1;
        err_mode_i = 2'(mode);
        @(posedge clk); #2;
        start_i = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            flip_req = flip && (k == 100);
            @(negedge clk);
            if (k < 16) cap[k] = cif.encoder_i_o;
            if (cif.err_inj_o == 2'd3) inj3++;
            if (cif.err_inj_o != 2'd0) injnz++;
            if (done_o) begin
                kd = k;
                break;
            end
            @(posedge clk); #2;
        end
        flip_req = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        logic [15:0] s, cap;
        int kd, inj3, injnz, nd, dn;
        int d [2];
        s = SEED;
        for (int n = 0; n < WORDS; n++) begin
            bits[n] = s[0];
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end

        fork
            forever begin
                @(negedge clk);
                cmp_cycle();
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lit_reset_busy", busy_o, 0);
        check("lit_reset_cct", chan_err_ct_o, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        run_one(0, 1'b0, kd, cap, inj3, injnz);
        check("lit_m0_latency", kd, WORDS + DL);
        check("lit_m0_seed_bits", cap, 16'hACE1);
        check("lit_m0_cct", chan_err_ct_o, 0);
        check("lit_m0_bct", bit_err_ct_o, 0);
        check("lit_m0_inj", injnz, 0);

        run_one(1, 1'b0, kd, cap, inj3, injnz);
        check("lit_m1_cct", chan_err_ct_o, 1);
        check("lit_m1_inj", injnz, 1);

        run_one(2, 1'b0, kd, cap, inj3, injnz);
        check("lit_m2_inj3", inj3, 1);
        check("lit_m2_cct", chan_err_ct_o, 2);
        check("lit_m2_bct", bit_err_ct_o, 0);

        run_one(3, 1'b0, kd, cap, inj3, injnz);
        check("lit_m3_inj3", inj3, 2);
        check("lit_m3_cct", chan_err_ct_o, 4);

        run_one(0, 1'b1, kd, cap, inj3, injnz);
        check("lit_flip_bct", bit_err_ct_o, 1);
        check("lit_flip_cct", chan_err_ct_o, 0);

        start_i = 1'b1;
        err_mode_i = 2'd3;
        @(posedge clk); #2;
        start_i = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("lit_abort_busy", busy_o, 0);
        check("lit_abort_cct", chan_err_ct_o, 0);
        check("lit_abort_bct", bit_err_ct_o, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_o) dn++;
        end
        check("lit_abort_no_done", dn, 0);
        @(posedge clk); #2;

        run_one(0, 1'b0, kd, cap, inj3, injnz);
        check("lit_rerun_seed_bits", cap, 16'hACE1);
        check("lit_rerun_latency", kd, WORDS + DL);
        check("lit_rerun_cct", chan_err_ct_o, 0);

        nd = 0;
        d[0] = 0; d[1] = 0;
        start_i = 1'b1;
        err_mode_i = 2'd0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done_o) begin
                d[nd] = k;
                nd++;
                if (nd == 2) break;
            end
            @(posedge clk); #2;
        end
        @(posedge clk); #2;
        start_i = 1'b0;
        check("lit_b2b_dones", nd, 2);
        check("lit_b2b_spacing", d[1] - d[0], WORDS + DL + 2);

        repeat (10) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/viterbi_ber_ctrl.md
VITERBI_BER_CTRL -- requirements
Module: viterbi_ber_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- WORDS, 256, input bits per test run (2..65535).
- ERR_PERIOD, 156, channel-word spacing of injected errors (>=2).
- DEC_LAT, 48, decoder latency in cycles from enable_decoder_o to matching dec_d_i.
- SEED, 16'hACE1, LFSR reset/start value (nonzero).
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- start_i, in, 1, begin run; sampled in IDLE only.
- err_mode_i, in, 2, 0 none, 1 flip bit[0], 2 flip both bits, 3 flip both bits on two consecutive words; latched at start.
- encoder_i_o, out, 1, data bit to encoder.
- enable_encoder_o, out, 1, encoder enable.
- enc_valid_i, in, 1, encoder output valid.
- enc_d_i, in, 2, encoder symbol.
- chan_o, out, 2, possibly corrupted symbol to decoder.
- enable_decoder_o, out, 1, decoder enable.
- dec_d_i, in, 1, decoder output bit.
- busy_o, out, 1, high in RUN or DRAIN.
- done_o, out, 1, one-cycle pulse at run completion.
- err_inj_o, out, 2, bits flipped on chan_o this cycle.
- chan_err_ct_o, out, 16, channel bits flipped this run.
- bit_err_ct_o, out, 16, decoded bit mismatches this run.

Function
REQ-003 FSM states: IDLE, RUN, DRAIN, DONE; single state register.
REQ-004 IDLE -> RUN when start_i=1; same edge: LFSR=SEED, counters cleared, err_mode_i latched; start_i ignored outside IDLE.
REQ-005 RUN: enable_encoder_o=1 for exactly WORDS cycles; encoder_i_o=lfsr[0]; LFSR advances each RUN cycle; polynomial x^16+x^14+x^13+x^11+1, Fibonacci, shift right, feedback into bit 15.
REQ-006 RUN -> DRAIN after the WORDS-th cycle; DRAIN lasts DEC_LAT+2 cycles; enable_encoder_o=0, encoder_i_o=0.
REQ-007 DRAIN -> DONE; DONE asserts done_o for one cycle, then IDLE; counts hold until next start.
REQ-008 Channel stage (all states): chan_o and enable_decoder_o registered one cycle after enc_d_i/enc_valid_i; chan_o = enc_d_i XOR mask.
REQ-009 Word index w counts valid channel words from 0 per run; mask nonzero only when enc_valid_i=1 and w mod ERR_PERIOD == ERR_PERIOD-1 (mode 3: also next valid word); mask per err_mode_i; err_inj_o equals mask, registered alongside chan_o.
REQ-010 chan_err_ct_o += popcount(mask) per injected word.
REQ-011 Reference path: each RUN input bit tagged valid, delayed DEC_LAT+2 cycles; when the delayed tag is valid, compare dec_d_i; mismatch increments bit_err_ct_o.
REQ-012 Both counters saturate at 16'hFFFF, no wrap.
REQ-013 Injection and compare occur only in RUN/DRAIN; in IDLE/DONE mask=0, counters frozen.

Reset
REQ-014 rst=0 asynchronously forces IDLE, LFSR=SEED, delay line cleared, all outputs 0 including counters.
REQ-015 Reset mid-run aborts; no done_o pulse; next run starts cleanly after start_i.

Verification
REQ-016 Mode 0, WORDS=256, ideal encoder/decoder -> chan_err_ct_o=0, bit_err_ct_o=0, done_o once, 256+DEC_LAT+2 cycles after start.
REQ-017 Mode 2, ERR_PERIOD=156, WORDS=256 -> word 155 inverted, err_inj_o=3 once, chan_err_ct_o=2.
REQ-018 Mode 3 -> words 155 and 156 inverted, chan_err_ct_o=4.
REQ-019 Decoder model inverting one output bit -> bit_err_ct_o=1.
REQ-020 Reset at RUN cycle 100, then start -> counters 0, encoder_i_o sequence restarts from SEED.
REQ-021 start_i held high throughout -> back-to-back runs, start ignored while busy_o=1.
